uart_transmitter: RTL and testbench

Standalone UART serializer for the communication-and-control domain. It pulls bytes from a first-word-fall-through transmit FIFO and drives them onto the tx line. Each frame is sent as 8N1 by default, LSB first, with an optional parity bit and 1 or 2 stop bits. The frame format matches what the uart receive path decodes, so tx can be looped back to rx in system benches.

---
 rtl/uart_transmitter.sv | 190 +++++++++++++++++++
 tb/tb_uart_transmitter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: pulls bytes from a first-word-fall-through transmit FIFO
// and serializes them onto tx as start / data (LSB first) / optional parity /
// 1 or 2 stop bits. Back-to-back frames are sent with no idle gap while the
// FIFO stays non-empty.
module uart_transmitter #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUDRATE  = 115200,
    parameter int BITLEN    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [BITLEN-1:0] data_in,
    input  logic              in_empty,
    output logic              in_read,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);
    timeunit 1ns;
    timeprecision 1ps;

    localparam int CPB = CLK_FREQ / BAUDRATE;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BW  = (BITLEN > 1) ? $clog2(BITLEN) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(CPB - 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITLEN - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic          HAS_PAR   = (PARITY != 0) ? 1'b1 : 1'b0;
    localparam logic          ODD_PAR   = (PARITY == 1) ? 1'b1 : 1'b0;

    // Configurations the frame logic cannot represent are rejected up front.
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_transmitter: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end
    if (CPB < 2) begin : g_bad_cpb
        $error("uart_transmitter: CLK_FREQ/BAUDRATE must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;       // clk cycles within the current bit
    logic [BW-1:0]     bit_q;       // data bit index
    logic              stop_q;      // stop bit index
    logic [BITLEN-1:0] shift_q;
    logic              par_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    // High exactly in the cycles where a new word may be taken: IDLE and
    // the final stop cycle. Registered so the pop strobe is a single gate
    // away from flops.
    logic              load_pt_q;

    logic              load_s;
    logic              cnt_end_s;
    logic [BITLEN-1:0] shift_nxt_s;

    assign load_s      = load_pt_q & ~in_empty;
    assign cnt_end_s   = (cnt_q == CNT_LAST);
    assign shift_nxt_s = {1'b0, shift_q[BITLEN-1:1]};

    // The pop strobe is masked during reset so an aborted cycle never
    // consumes a FIFO word.
    assign in_read = load_s & rstb;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

    // Frame sequencer: bit timing, serialization and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            bit_q     <= {BW{1'b0}};
            stop_q    <= 1'b0;
            shift_q   <= {BITLEN{1'b0}};
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_pt_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (load_s) begin
                // Take the FIFO head word; the start bit begins next cycle.
                state_q   <= S_START;
                shift_q   <= data_in;
                par_q     <= (^data_in) ^ ODD_PAR;
                cnt_q     <= {CW{1'b0}};
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
                load_pt_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tx_q      <= 1'b1;
                        busy_q    <= 1'b0;
                        load_pt_q <= 1'b1;
                    end
                    S_START: begin
                        if (cnt_end_s) begin
                            cnt_q   <= {CW{1'b0}};
                            bit_q   <= {BW{1'b0}};
                            tx_q    <= shift_q[0];
                            state_q <= S_DATA;
                        end else begin
                            cnt_q <= cnt_q + CW'(1'b1);
                        end
                    end
                    S_DATA: begin
                        if (cnt_end_s) begin
                            cnt_q   <= {CW{1'b0}};
                            shift_q <= shift_nxt_s;
                            if (bit_q == BIT_LAST) begin
                                if (HAS_PAR) begin
                                    state_q <= S_PARITY;
                                    tx_q    <= par_q;
                                end else begin
                                    state_q <= S_STOP;
                                    tx_q    <= 1'b1;
                                    stop_q  <= 1'b0;
                                end
                            end else begin
                                bit_q <= bit_q + BW'(1'b1);
                                tx_q  <= shift_nxt_s[0];
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1'b1);
                        end
                    end
                    S_PARITY: begin
                        if (cnt_end_s) begin
                            cnt_q   <= {CW{1'b0}};
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                            stop_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1'b1);
                        end
                    end
                    S_STOP: begin
                        if (cnt_end_s) begin
                            cnt_q <= {CW{1'b0}};
                            if (stop_q == STOP_LAST) begin
                                // FIFO was empty on the final cycle.
                                state_q   <= S_IDLE;
                                tx_q      <= 1'b1;
                                busy_q    <= 1'b0;
                                load_pt_q <= 1'b1;
                            end else begin
                                stop_q <= stop_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1'b1);
                            // Entering the final stop cycle: flag it.
                            if (stop_q == STOP_LAST && cnt_q == CNT_PRE) begin
                                done_q    <= 1'b1;
                                load_pt_q <= 1'b1;
                            end else begin
                                done_q    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        cnt_q     <= {CW{1'b0}};
                        tx_q      <= 1'b1;
                        busy_q    <= 1'b0;
                        load_pt_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: four instances cover no parity, even
// parity, odd parity and two stop bits. A FWFT FIFO is modelled in the bench
// and a line-level reference model predicts tx/busy/tx_done/in_read on every
// cycle; table rows and hand sequences add frame-level checks.
module tb_uart_transmitter;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int NCFG     = 4;

    // Configuration per instance: 0 none/1stop, 1 even, 2 odd, 3 none/2stop.
    function automatic int par_of(input int c);
        case (c)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int c);
        return (c == 3) ? 2 : 1;
    endfunction

    logic             clk  = 1'b0;
    logic             rstb = 1'b0;
    logic [7:0]       data_v [NCFG] = '{default: 8'h00};
    logic [NCFG-1:0]  in_empty_v = 4'hF;
    logic [NCFG-1:0]  in_read_w;
    logic [NCFG-1:0]  tx_w;
    logic [NCFG-1:0]  busy_w;
    logic [NCFG-1:0]  done_w;

    always #500 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        uart_transmitter #(
            .CLK_FREQ (CLK_FREQ),
            .BAUDRATE (BAUD),
            .BITLEN   (8),
            .PARITY   (par_of(g)),
            .STOP_BITS(stop_of(g))
        ) u_dut (
            .clk     (clk),
            .rstb    (rstb),
            .data_in (data_v[g]),
            .in_empty(in_empty_v[g]),
            .in_read (in_read_w[g]),
            .tx      (tx_w[g]),
            .busy    (busy_w[g]),
            .tx_done (done_w[g])
        );
    end

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        int         cfg;
        logic [7:0] data;
        int         exp_len;
        bit         has_par;
        logic       exp_par;
    } row_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_mem [256];
    int         wr_ptr   = 0;
    int         rd_ptr   = 0;
    int         pop_req  = 0;
    int         pop_done = 0;
    int         sel      = 0;
    bit         skip_cyc = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;
    row_t       rows [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    // Expected line for one frame, one entry per clock cycle.
    function automatic void add_frame(input logic [7:0] b, input int par, input int stops);
        bit   line[$];
        int   total;
        int   k;
        exp_t e;
        line.push_back(1'b0);
        for (int i = 0; i < 8; i++) line.push_back(b[i]);
        if (par == 2) line.push_back(^b);
        else if (par == 1) line.push_back(~^b);
        for (int s = 0; s < stops; s++) line.push_back(1'b1);
        total = line.size() * CPB;
        k = 0;
        foreach (line[j]) begin
            for (int c = 0; c < CPB; c++) begin
                e.tx   = line[j];
                e.busy = 1'b1;
                e.done = (k == total - 1);
                exp_q.push_back(e);
                k++;
            end
        end
    endfunction

    // FWFT FIFO drive: pops follow an accepted read, inputs change after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_req != pop_done) begin
                rd_ptr++;
                pop_done++;
            end
            for (int i = 0; i < NCFG; i++) begin
                if (i == sel && wr_ptr != rd_ptr) begin
                    in_empty_v[i] = 1'b0;
                    data_v[i]     = fifo_mem[rd_ptr[7:0]];
                end else begin
                    in_empty_v[i] = 1'b1;
                    data_v[i]     = 8'h00;
                end
            end
        end
    end

    // One clock cycle: sample at the falling edge and compare with the model.
    task automatic tick();
        exp_t cur;
        bit   exp_rd;
        @(negedge clk);
        if (skip_cyc) begin
            skip_cyc = 1'b0;
        end else begin
            if (!rstb) exp_q.delete();
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else begin
                cur.tx = 1'b1; cur.busy = 1'b0; cur.done = 1'b0;
            end
            exp_rd = rstb && (exp_q.size() == 0) && !in_empty_v[sel];
            check("tx", tx_w[sel], cur.tx);
            check("busy", busy_w[sel], cur.busy);
            check("tx_done", done_w[sel], cur.done);
            check("in_read", in_read_w[sel], exp_rd);
            if (exp_rd) begin
                add_frame(data_v[sel], par_of(sel), stop_of(sel));
                pop_req++;
            end
        end
    endtask

    // Run until the busy period ends, collecting frame-level observations.
    task automatic run_capture(input int max_cyc, output int blen, output int ndone,
                               output int last_done, output int nrd, output int rd_gap,
                               output logic [7:0] got, output logic [7:0] got2,
                               output logic parb);
        int prev_rd;
        bit seen;
        bit fin;
        int c;
        blen = 0; ndone = 0; last_done = 0; nrd = 0; rd_gap = 0;
        got = 8'h00; got2 = 8'h00; parb = 1'b0;
        prev_rd = -1; seen = 1'b0; fin = 1'b0; c = 0;
        while (!fin && c < max_cyc) begin
            tick();
            if (in_read_w[sel]) begin
                nrd++;
                if (prev_rd >= 0) rd_gap = c - prev_rd;
                prev_rd = c;
            end
            if (busy_w[sel]) begin
                blen++;
                seen = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    if (blen == CPB * (i + 1) + CPB / 2) got[i] = tx_w[sel];
                    if (blen == 100 + CPB * (i + 1) + CPB / 2) got2[i] = tx_w[sel];
                end
                if (blen == CPB * 9 + CPB / 2) parb = tx_w[sel];
                if (done_w[sel]) begin
                    ndone++;
                    last_done = blen;
                end
            end else if (seen) begin
                fin = 1'b1;
            end
            c++;
        end
        check("capture_complete", fin, 1);
    endtask

    initial begin
        int blen, ndone, last_done, nrd, rd_gap, g, cnt, rd, bz, dn, low;
        logic [7:0] got, got2;
        logic parb;

        rows[0] = '{0, 8'h03, 100, 1'b0, 1'b0};
        rows[1] = '{1, 8'h07, 110, 1'b1, 1'b1};
        rows[2] = '{2, 8'h07, 110, 1'b1, 1'b0};
        rows[3] = '{3, 8'hA5, 110, 1'b0, 1'b0};
        rows[4] = '{1, 8'hA5, 110, 1'b1, 1'b0};
        rows[5] = '{2, 8'h00, 110, 1'b1, 1'b1};
        rows[6] = '{3, 8'h80, 110, 1'b0, 1'b0};

        // Reset state on every instance.
        repeat (3) tick();
        check("reset_tx_all", tx_w, 4'hF);
        check("reset_busy_all", busy_w, 4'h0);
        check("reset_read_all", in_read_w, 4'h0);
        @(posedge clk); #1 rstb = 1'b1;

        // Empty FIFO for 500 cycles: the line must stay idle.
        rd = 0; bz = 0; dn = 0; low = 0;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (in_read_w[0]) rd++;
            if (busy_w[0]) bz++;
            if (done_w[0]) dn++;
            if (!tx_w[0]) low++;
        end
        check("idle_reads", rd, 0);
        check("idle_busy", bz, 0);
        check("idle_done", dn, 0);
        check("idle_tx_low", low, 0);

        // Single frames across configurations.
        for (int r = 0; r < 7; r++) begin
            sel = rows[r].cfg;
            push(rows[r].data);
            run_capture(400, blen, ndone, last_done, nrd, rd_gap, got, got2, parb);
            check("tbl_len", blen, rows[r].exp_len);
            check("tbl_done_cnt", ndone, 1);
            check("tbl_done_pos", last_done, rows[r].exp_len);
            check("tbl_reads", nrd, 1);
            check("tbl_data", got, rows[r].data);
            if (rows[r].has_par) check("tbl_parity", parb, rows[r].exp_par);
            repeat (2) tick();
        end

        // Back-to-back frames with the FIFO kept non-empty.
        sel = 0;
        push(8'h05);
        push(8'h09);
        run_capture(600, blen, ndone, last_done, nrd, rd_gap, got, got2, parb);
        check("b2b_len", blen, 200);
        check("b2b_reads", nrd, 2);
        check("b2b_read_gap", rd_gap, 100);
        check("b2b_done_cnt", ndone, 2);
        check("b2b_done_pos", last_done, 200);
        check("b2b_byte0", got, 8'h05);
        check("b2b_byte1", got2, 8'h09);
        repeat (2) tick();

        // Reset in the middle of data bit 2 of a 0xFF frame.
        push(8'hFF);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!in_read_w[0] && cnt < 50);
        check("abort_read_seen", in_read_w[0], 1);
        repeat (34) tick();
        @(posedge clk); #1; rstb = 1'b0; skip_cyc = 1'b1;
        tick();
        tick();
        check("abort_tx", tx_w[0], 1);
        check("abort_busy", busy_w[0], 0);
        @(posedge clk); #1 rstb = 1'b1;
        rd = 0; low = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (in_read_w[0]) rd++;
            if (!tx_w[0]) low++;
        end
        check("abort_no_reread", rd, 0);
        check("abort_tx_idle", low, 0);

        // Random bytes with random arrival times, every cycle checked by the model.
        for (int cfg = 0; cfg < NCFG; cfg++) begin
            sel = cfg;
            for (int k = 0; k < 6; k++) begin
                push(8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 130)) tick();
            end
            g = 0;
            while ((wr_ptr != rd_ptr || exp_q.size() != 0) && g < 3000) begin
                tick();
                g++;
            end
            check("random_drain", (g < 3000), 1);
            repeat (2) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the run never reaches its summary.
    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
